// File: rtl/fir_ctrl_pkg.sv
// Shared constants, FSM states and coefficient type for the FIR coefficient controller.
package fir_ctrl_pkg;
   localparam int NT = 11;
   localparam int NB = 9;
   localparam int AW = 4;

   localparam logic [AW-1:0] NT_A     = AW'(NT);
   localparam logic [AW-1:0] CNT_LAST = AW'(NT - 1);

   typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_SWAP} state_t;
   typedef logic signed [NB-1:0] coef_t;
endpackage

// File: rtl/fir_coef_bank.sv
// Shadow/active coefficient register banks with write port, swap strobe and packed tap output.
// FIR_COEF_READBACK_EN adds a registered readback of either bank.
module fir_coef_bank
   import fir_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [NB-1:0]    wdata,
   input  logic             swap,
`ifdef FIR_COEF_READBACK_EN
   input  logic [AW-1:0]    rd_addr,
   input  logic             rd_sel,
   output logic [NB-1:0]    rd_data,
`endif
   output logic [NT*NB-1:0] coef
);
   logic [NT-1:0][NB-1:0] shadow;
   logic [NT-1:0][NB-1:0] active;

   // Addresses past the last tap match no entry, so those writes fall away.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow <= '0;
         active <= '0;
      end else begin
         for (int k = 0; k < NT; k++) begin
            if (we && waddr == AW'(k)) shadow[k] <= wdata;
            if (swap)                  active[k] <= shadow[k];
         end
      end
   end

   assign coef = active;

`ifdef FIR_COEF_READBACK_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rd_data <= '0;
      else if (rd_addr < NT_A)
         rd_data <= rd_sel ? active[rd_addr] : shadow[rd_addr];
      else
         rd_data <= '0;
   end
`endif
endmodule

// File: rtl/fir_coef_ctrl.sv
// Sample sequencer for the 11-tap FIR: forwards samples, flushes with zeros on commit, then swaps coefficients.
// FIR_COEF_READBACK_EN adds RD_ADDR/RD_SEL/RD_DATA coefficient readback.
module fir_coef_ctrl
   import fir_ctrl_pkg::*;
(
   input  logic             CLK,
   input  logic             RST_n,
   input  logic [NB-1:0]    SRC_DIN,
   input  logic             SRC_VIN,
   output logic             SRC_READY,
   input  logic             CFG_WE,
   input  logic [AW-1:0]    CFG_ADDR,
   input  logic [NB-1:0]    CFG_DATA,
   input  logic             CFG_COMMIT,
   output logic             CFG_BUSY,
`ifdef FIR_COEF_READBACK_EN
   input  logic [AW-1:0]    RD_ADDR,
   input  logic             RD_SEL,
   output logic [NB-1:0]    RD_DATA,
`endif
   output logic [NB-1:0]    DIN,
   output logic             VIN,
   output logic             FLUSH,
   output logic [NT*NB-1:0] COEF
);
   state_t        state, state_nx;
   logic [AW-1:0] cnt, cnt_nx;
   logic [NB-1:0] din_nx;
   logic          vin_nx, flush_nx;
   logic          wr_en, swap;

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state <= ST_RUN;
         cnt   <= '0;
         DIN   <= '0;
         VIN   <= 1'b0;
         FLUSH <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         DIN   <= din_nx;
         VIN   <= vin_nx;
         FLUSH <= flush_nx;
      end
   end

   // Outputs trail the state by one cycle, so the sample taken with the commit leads the flush beats.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      din_nx   = '0;
      vin_nx   = 1'b0;
      flush_nx = 1'b0;
      case (state)
         ST_RUN: begin
            din_nx = SRC_DIN;
            vin_nx = SRC_VIN;
            if (CFG_COMMIT) begin
               state_nx = ST_DRAIN;
               cnt_nx   = '0;
            end
         end
         ST_DRAIN: begin
            vin_nx   = 1'b1;
            flush_nx = 1'b1;
            if (cnt == CNT_LAST) begin
               state_nx = ST_SWAP;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt + AW'(1);
            end
         end
         ST_SWAP:  state_nx = ST_RUN;
         default:  state_nx = ST_RUN;
      endcase
   end

   // Gated by reset so the source is held off while RST_n is low.
   assign SRC_READY = RST_n & (state == ST_RUN);
   assign CFG_BUSY  = (state != ST_RUN);
   assign wr_en     = CFG_WE & ~CFG_BUSY;
   assign swap      = (state == ST_SWAP);

   fir_coef_bank u_bank (
      .clk     (CLK),
      .rst_n   (RST_n),
      .we      (wr_en),
      .waddr   (CFG_ADDR),
      .wdata   (CFG_DATA),
      .swap    (swap),
`ifdef FIR_COEF_READBACK_EN
      .rd_addr (RD_ADDR),
      .rd_sel  (RD_SEL),
      .rd_data (RD_DATA),
`endif
      .coef    (COEF)
   );
endmodule

// File: tb/tb_fir_coef_ctrl.sv
// Directed + randomized bench for fir_coef_ctrl against a bank/stream reference model.
// Honours FIR_COEF_READBACK_EN when the design is built with it.
module tb_fir_coef_ctrl;
   import fir_ctrl_pkg::*;

   logic             CLK = 1'b0;
   logic             RST_n = 1'b0;
   logic [NB-1:0]    SRC_DIN = '0;
   logic             SRC_VIN = 1'b0;
   logic             SRC_READY;
   logic             CFG_WE = 1'b0;
   logic [AW-1:0]    CFG_ADDR = '0;
   logic [NB-1:0]    CFG_DATA = '0;
   logic             CFG_COMMIT = 1'b0;
   logic             CFG_BUSY;
   logic [NB-1:0]    DIN;
   logic             VIN;
   logic             FLUSH;
   logic [NT*NB-1:0] COEF;
`ifdef FIR_COEF_READBACK_EN
   logic [AW-1:0]    RD_ADDR = '0;
   logic             RD_SEL = 1'b0;
   logic [NB-1:0]    RD_DATA;
`endif

   int checks = 0;
   int errors = 0;
   int shadow_m [NT];
   int active_m [NT];

   always #5 CLK = ~CLK;

   fir_coef_ctrl dut (
      .CLK(CLK), .RST_n(RST_n),
      .SRC_DIN(SRC_DIN), .SRC_VIN(SRC_VIN), .SRC_READY(SRC_READY),
      .CFG_WE(CFG_WE), .CFG_ADDR(CFG_ADDR), .CFG_DATA(CFG_DATA),
      .CFG_COMMIT(CFG_COMMIT), .CFG_BUSY(CFG_BUSY),
`ifdef FIR_COEF_READBACK_EN
      .RD_ADDR(RD_ADDR), .RD_SEL(RD_SEL), .RD_DATA(RD_DATA),
`endif
      .DIN(DIN), .VIN(VIN), .FLUSH(FLUSH), .COEF(COEF)
   );

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chkd(input string tag, input logic [NB-1:0] obs, input logic [NB-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chkc(input string tag, input logic [NT*NB-1:0] obs, input logic [NT*NB-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [NT*NB-1:0] exp_coef();
      logic [NT*NB-1:0] r;
      r = '0;
      for (int k = 0; k < NT; k++) r[k*NB +: NB] = NB'(active_m[k]);
      return r;
   endfunction

   // Software write issued in a RUN cycle; out-of-range taps do not exist in the model.
   task automatic wr(input int addr, input int data);
      CFG_WE = 1'b1; CFG_ADDR = AW'(addr); CFG_DATA = NB'(data);
      tick();
      CFG_WE = 1'b0;
      if (addr < NT) shadow_m[addr] = data;
   endtask

   // Full commit: forwarded sample, NT flush beats, NT+1 busy cycles, then the new bank.
   task automatic commit_seq(input bit we, input int addr, input int data, input bit inject);
      logic [NT*NB-1:0] old_c;
      logic [NB-1:0]    s;
      int busy_n, flush_n;
      old_c = exp_coef();
      s = NB'($urandom);
      SRC_DIN = s; SRC_VIN = 1'b1; CFG_COMMIT = 1'b1;
      if (we) begin
         CFG_WE = 1'b1; CFG_ADDR = AW'(addr); CFG_DATA = NB'(data);
         if (addr < NT) shadow_m[addr] = data;
      end
      tick();
      CFG_COMMIT = 1'b0; CFG_WE = 1'b0; SRC_DIN = NB'($urandom);
      chkd("commit_fwd_din", DIN, s);
      chkb("commit_fwd_vin", VIN, 1'b1);
      chkb("commit_fwd_flush", FLUSH, 1'b0);
      busy_n = 0; flush_n = 0;
      while (CFG_BUSY === 1'b1 && busy_n < 40) begin
         busy_n++;
         chkb("busy_ready", SRC_READY, 1'b0);
         chkc("busy_coef_stable", COEF, old_c);
         if (inject && busy_n == 5) begin
            CFG_WE = 1'b1; CFG_ADDR = AW'(2); CFG_DATA = NB'(7); CFG_COMMIT = 1'b1;
         end
         tick();
         CFG_WE = 1'b0; CFG_COMMIT = 1'b0;
         if (VIN === 1'b1 && FLUSH === 1'b1 && DIN === '0) flush_n++;
      end
      SRC_VIN = 1'b0;
      for (int k = 0; k < NT; k++) active_m[k] = shadow_m[k];
      chki("busy_cycles", busy_n, NT + 1);
      chki("flush_beats", flush_n, NT);
      chkc("coef_after_swap", COEF, exp_coef());
      chkb("post_swap_vin", VIN, 1'b0);
      chkb("post_swap_flush", FLUSH, 1'b0);
      chkb("post_swap_ready", SRC_READY, 1'b1);
   endtask

   initial begin
      logic [NB-1:0] d;
      logic          v;
      for (int k = 0; k < NT; k++) begin shadow_m[k] = 0; active_m[k] = 0; end

      // Reset values while RST_n is held low
      #12;
      chkb("rst_ready", SRC_READY, 1'b0);
      chkb("rst_vin", VIN, 1'b0);
      chkb("rst_flush", FLUSH, 1'b0);
      chkb("rst_busy", CFG_BUSY, 1'b0);
      chkd("rst_din", DIN, '0);
      chkc("rst_coef", COEF, '0);
`ifdef FIR_COEF_READBACK_EN
      chkd("rst_rd_data", RD_DATA, '0);
`endif
      @(negedge CLK);
      RST_n = 1'b1;
      tick();
      chkb("run_ready", SRC_READY, 1'b1);

      // Streaming: fixed 1,2,3 then random data/valid
      for (int i = 1; i <= 3; i++) begin
         SRC_DIN = NB'(i); SRC_VIN = 1'b1;
         tick();
         chkd("stream_din", DIN, NB'(i));
         chkb("stream_vin", VIN, 1'b1);
         chkb("stream_flush", FLUSH, 1'b0);
         chkc("stream_coef", COEF, '0);
      end
      for (int i = 0; i < 8; i++) begin
         d = NB'($urandom); v = 1'($urandom_range(0, 1));
         SRC_DIN = d; SRC_VIN = v;
         tick();
         chkd("rand_din", DIN, d);
         chkb("rand_vin", VIN, v);
         chkb("rand_flush", FLUSH, 1'b0);
      end
      SRC_VIN = 1'b0;

      // Load taps k+1 and commit
      for (int k = 0; k < NT; k++) wr(k, k + 1);
      commit_seq(1'b0, 0, 0, 1'b0);

      // Write in the commit cycle is applied by that commit
      commit_seq(1'b1, 5, -3, 1'b0);
      chkd("tap5_same_cycle", COEF[5*NB +: NB], 9'h1FD);

      // Write and second commit during drain are both dropped
      commit_seq(1'b0, 0, 0, 1'b1);
      chkd("tap2_unchanged", COEF[2*NB +: NB], 9'd3);

      // Out-of-range writes plus random in-range writes, then readback and commit
      wr(11, $urandom);
      wr(15, $urandom);
      for (int i = 0; i < 10; i++) wr($urandom_range(0, 15), $urandom);
`ifdef FIR_COEF_READBACK_EN
      for (int k = 0; k < 16; k++) begin
         RD_ADDR = AW'(k); RD_SEL = 1'b0;
         tick();
         chkd("rd_shadow", RD_DATA, (k < NT) ? NB'(shadow_m[k]) : '0);
         RD_SEL = 1'b1;
         tick();
         chkd("rd_active", RD_DATA, (k < NT) ? NB'(active_m[k]) : '0);
      end
`endif
      commit_seq(1'b0, 0, 0, 1'b0);

      // Reset in the middle of drain cancels the swap and clears both banks
      for (int k = 0; k < NT; k++) wr(k, $urandom);
      CFG_COMMIT = 1'b1;
      tick();
      CFG_COMMIT = 1'b0;
      repeat (4) tick();
      chkb("drain4_flush", FLUSH, 1'b1);
      #2;
      RST_n = 1'b0;
      #1;
      chkb("midrst_vin", VIN, 1'b0);
      chkb("midrst_flush", FLUSH, 1'b0);
      chkb("midrst_busy", CFG_BUSY, 1'b0);
      chkb("midrst_ready", SRC_READY, 1'b0);
      chkc("midrst_coef", COEF, '0);
      for (int k = 0; k < NT; k++) begin shadow_m[k] = 0; active_m[k] = 0; end
      @(negedge CLK);
      RST_n = 1'b1;
      tick();
      chkb("after_rst_ready", SRC_READY, 1'b1);
      commit_seq(1'b0, 0, 0, 1'b0);
      chkc("shadow_cleared", COEF, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
